mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have one parameter, ADDR_BITS, default 10, giving the data-memory word-address width (1024 words of 64 bits).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port req_valid, input, 1 bit: a CPU load/store request is present.
REQ-005 The block SHALL have port req_ready, output, 1 bit: the unit accepts a request this cycle.
REQ-006 The block SHALL have port req_store, input, 1 bit: 1 = STUR, 0 = LDUR.
REQ-007 The block SHALL have port req_base, input, 64 bits: base register value (byte address).
REQ-008 The block SHALL have port req_offset, input, 9 bits: signed DT_address byte offset.
REQ-009 The block SHALL have port req_wdata, input, 64 bits: store data.
REQ-010 The block SHALL have port rsp_valid, output, 1 bit: a response is present.
REQ-011 The block SHALL have port rsp_ready, input, 1 bit: the CPU consumes the response.
REQ-012 The block SHALL have port rsp_rdata, output, 64 bits: load data; 0 for stores and errors.
REQ-013 The block SHALL have port rsp_error, output, 1 bit: the request was misaligned or out of range.
REQ-014 The block SHALL have port mem_addr, output, ADDR_BITS bits: word address to the data memory.
REQ-015 The block SHALL have port mem_wdata, output, 64 bits: write data to the data memory.
REQ-016 The block SHALL have port mem_write, output, 1 bit: write strobe; the memory acts on its rising edge.
REQ-017 The block SHALL have port mem_read, output, 1 bit: read strobe; the memory acts on its rising edge.
REQ-018 The block SHALL have port mem_rdata, input, 64 bits: read data from the data memory.

Function
REQ-019 All outputs SHALL be registered; mem_read and mem_write SHALL be glitch-free and never high in the same cycle.
REQ-020 The FSM SHALL have four states: IDLE, SETUP, STROBE and RESP; req_ready SHALL be 1 only in IDLE.
REQ-021 A request SHALL be accepted on an edge where req_valid and req_ready are both 1; at that edge the unit SHALL latch store, wdata and EA = (req_base + sign-extended req_offset) mod 2^64.
REQ-022 The request SHALL be an error if EA[2:0] != 0 or EA[63:ADDR_BITS+3] != 0.
REQ-023 On an error request the FSM SHALL go IDLE -> RESP, with no strobe, rsp_error = 1 and rsp_rdata = 0.
REQ-024 On a valid request the FSM SHALL go IDLE -> SETUP, driving mem_addr = EA[ADDR_BITS+2:3] and mem_wdata = the latched data, with both strobes 0.
REQ-025 The FSM SHALL go SETUP -> STROBE, asserting exactly one strobe (mem_write for a store, mem_read for a load) for exactly one cycle.
REQ-026 The FSM SHALL go STROBE -> RESP; on that edge rsp_rdata SHALL capture mem_rdata for a load, or 0 for a store, the strobe SHALL drop, and rsp_error SHALL be 0.
REQ-027 rsp_valid SHALL first be 1 three cycles after the acceptance edge (one cycle for an error request).
REQ-028 In RESP, rsp_valid, rsp_rdata and rsp_error SHALL hold stable until an edge with rsp_ready = 1, after which the FSM SHALL return to IDLE and rsp_valid SHALL be 0.
REQ-029 mem_addr and mem_wdata SHALL remain stable from SETUP until the next accepted valid request.
REQ-030 Minimum spacing between accepted requests SHALL be 4 cycles; req_valid SHALL be ignored outside IDLE.

Reset
REQ-031 While reset is high at a clock edge, the FSM SHALL go to IDLE, and rsp_valid, rsp_error, mem_read and mem_write SHALL be set to 0.
REQ-032 While reset is high at a clock edge, rsp_rdata, mem_addr and mem_wdata SHALL be set to 0.
REQ-033 Reset SHALL take priority over every other event, including a mid-transaction reset.
REQ-034 If reset occurs in STROBE, the strobe SHALL drop at that edge and no response SHALL be produced; the write may already have been applied.
REQ-035 req_ready SHALL be 1 in the first cycle after reset is released.

Verification
REQ-036 Load, memory word 2 = 8: base 0x10, offset 0 -> mem_addr 2, one mem_read pulse, rsp_valid 3 cycles after acceptance, rsp_rdata 8, rsp_error 0.
REQ-037 Store then load: base 0x28, offset -8, data 0xDEAD -> mem_addr 4, one mem_write pulse, rsp_rdata 0; then a load from 0x20 -> rsp_rdata 0xDEAD.
REQ-038 Errors: base 0x11 (misaligned), and separately base 0x2000 (out of range) -> no strobes, rsp_valid 1 cycle after acceptance, rsp_error 1, rsp_rdata 0.
REQ-039 Backpressure: rsp_ready held low 4 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready 0, no strobes; rsp_ready 1 -> IDLE the next cycle.
REQ-040 Reset in STROBE of a load -> mem_read 0 and rsp_valid 0 the next cycle, req_ready 1 after release; a new load completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// ============================================================================
//  Module      : mem_access_unit
//  Description : LDUR/STUR data-memory access sequencer. Computes the
//                effective address, flags misaligned or out-of-range accesses
//                and drives a registered, glitch-free memory strobe interface.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit #(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_store,
    input  logic [63:0]          req_base,
    input  logic [8:0]           req_offset,
    input  logic [63:0]          req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [63:0]          rsp_rdata,
    output logic                 rsp_error,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [63:0]          mem_wdata,
    output logic                 mem_write,
    output logic                 mem_read,
    input  logic [63:0]          mem_rdata
);

    localparam int WORD_SHIFT = ADDR_BITS + 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t                 state_q,     state_d;
    logic                   store_q,     store_d;
    logic                   req_ready_q, req_ready_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [63:0]            rsp_rdata_q, rsp_rdata_d;
    logic                   rsp_error_q, rsp_error_d;
    logic [ADDR_BITS-1:0]   mem_addr_q,  mem_addr_d;
    logic [63:0]            mem_wdata_q, mem_wdata_d;
    logic                   mem_write_q, mem_write_d;
    logic                   mem_read_q,  mem_read_d;

    logic [63:0]            ea;
    logic                   ea_misaligned;
    logic                   ea_out_of_range;
    logic                   ea_error;

    // Effective address wraps modulo 2^64, so a negative offset from a small
    // base lands far above the memory and is reported as out of range.
    assign ea              = req_base + {{55{req_offset[8]}}, req_offset};
    assign ea_misaligned   = |ea[2:0];
    assign ea_out_of_range = |(ea >> WORD_SHIFT);
    assign ea_error        = ea_misaligned | ea_out_of_range;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            store_q     <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 64'd0;
            rsp_error_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 64'd0;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            store_q     <= store_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_write_q <= mem_write_d;
            mem_read_q  <= mem_read_d;
        end
    end

    // Every output is computed one state ahead so it can be registered;
    // req_ready_d is therefore "next state is IDLE".
    always_comb begin
        state_d     = state_q;
        store_d     = store_q;
        req_ready_d = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_write_d = 1'b0;
        mem_read_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid) begin
                    req_ready_d = 1'b0;
                    store_d     = req_store;
                    if (ea_error) begin
                        // Rejected requests leave the memory-side bus untouched.
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                        rsp_rdata_d = 64'd0;
                    end else begin
                        state_d     = ST_SETUP;
                        mem_addr_d  = ea[WORD_SHIFT-1:3];
                        mem_wdata_d = req_wdata;
                    end
                end
            end
            ST_SETUP: begin
                state_d     = ST_STROBE;
                mem_write_d = store_q;
                mem_read_d  = ~store_q;
            end
            ST_STROBE: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_error_d = 1'b0;
                rsp_rdata_d = store_q ? 64'd0 : mem_rdata;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_write = mem_write_q;
    assign mem_read  = mem_read_q;

    a_strobe_exclusive : assert property (@(posedge clk) disable iff (reset)
        !(mem_read_q && mem_write_q));
    a_read_single : assert property (@(posedge clk) disable iff (reset)
        mem_read_q |=> !mem_read_q);
    a_write_single : assert property (@(posedge clk) disable iff (reset)
        mem_write_q |=> !mem_write_q);

endmodule

`default_nettype wire
